axi_stream_insert_arbiter: RTL and testbench
============================================

Name: axi_stream_insert_arbiter

Overview:
- Shares one axi_stream_header_insert datapath between NUM_SRC packet sources.
- Each source presents a header channel (data_insert/keep_insert/byte_insert_cnt) and an AXI-Stream payload.
- Arbiter grants one source per packet and muxes its header and payload onto the insert block's slave ports.
- Grant is held until both that packet's header handshake and its last payload beat handshake have completed.

Parameters:
- DATA_WD, 32, payload/header data width in bits.
- DATA_BYTE_WD, DATA_WD/8, bytes per beat (keep width).
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), byte_insert_cnt width is BYTE_CNT_WD+1.
- NUM_SRC, 2, number of requesting sources (2..8).
- SRC_ID_WD, $clog2(NUM_SRC), grant index width (min 1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- s_valid_insert  in  NUM_SRC  per-source header valid; also that source's request.
- s_data_insert  in  NUM_SRC*DATA_WD  per-source header data, source i at slice i.
- s_keep_insert  in  NUM_SRC*DATA_BYTE_WD  per-source header keep.
- s_byte_insert_cnt  in  NUM_SRC*(BYTE_CNT_WD+1)  per-source header byte count.
- s_ready_insert  out  NUM_SRC  per-source header ready.
- s_valid_in  in  NUM_SRC  per-source payload valid.
- s_data_in  in  NUM_SRC*DATA_WD  per-source payload data.
- s_keep_in  in  NUM_SRC*DATA_BYTE_WD  per-source payload keep.
- s_last_in  in  NUM_SRC  per-source payload last.
- s_ready_in  out  NUM_SRC  per-source payload ready.
- m_valid_insert / m_data_insert / m_keep_insert / m_byte_insert_cnt  out  1/DATA_WD/DATA_BYTE_WD/BYTE_CNT_WD+1  header to insert block.
- m_ready_insert  in  1  header ready from insert block.
- m_valid_in / m_data_in / m_keep_in / m_last_in  out  1/DATA_WD/DATA_BYTE_WD/1  payload to insert block.
- m_ready_in  in  1  payload ready from insert block.
- grant_id  out  SRC_ID_WD  index of granted source (valid when busy=1).
- busy  out  1  a packet is granted.

Behaviour:
- States:
  - IDLE: busy=0, all m_valid_* = 0, all s_ready_* = 0.
  - GRANT: if any s_valid_insert bit is set, select a winner, register grant_id, set hdr_done=0, go to GRANT on the next edge. Grant latency is 1 cycle.
  - In GRANT: m_* = granted source's s_* (combinational mux from registered grant_id). s_ready_insert[g]=m_ready_insert and s_ready_in[g]=m_ready_in. All other s_ready_* = 0.
- hdr_done is set on m_valid_insert&m_ready_insert. Once set, m_valid_insert is forced to 0 and s_ready_insert[g]=0, so a second header queued by the same source is not consumed in this packet.
- Packet end is a last handshake: m_valid_in&m_ready_in&m_last_in.
  - End with hdr_done=1, or with the header handshake in the same cycle → IDLE, pointer updated.
  - End before the header handshake → latch last_done, keep forwarding the header only (payload ready=0), exit on the header handshake.
- Round-robin: pointer holds the last granted index. Search starts at pointer+1 and wraps modulo NUM_SRC. Pointer resets to NUM_SRC-1, so source 0 wins first.
- Payload beats may arrive before the header is granted; they are simply not acknowledged. There is no arbitration on s_valid_in alone.
- No cycle is lost between packets beyond the 1-cycle IDLE grant decision.
- Reset (rst_n=0 at an edge), including mid-packet:
  - state=IDLE, grant_id=0, busy=0, hdr_done=0, last_done=0, pointer=NUM_SRC-1.
  - All outputs 0 from the cycle after that edge.
- Masters must not drop s_valid_* before handshake; the arbiter does not check this.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
  - Defined: fixed priority, lowest requesting index always wins in IDLE; pointer logic removed.
  - Undefined: round-robin as above.

Test Plan:
- Reset then source 0 only: header 0xA5A5A5A5, keep 4'b0011, cnt 2, payload 3 beats, last keep 4'b1100 → grant_id=0 one cycle after request; m_* mirror source 0; busy drops the cycle after the last handshake.
- Both sources request in the same cycle, each 2-beat packets → order 0,1,0,1 over four packets (round-robin); with ARB_FIXED_PRIO_EN, source 0 wins every contention.
- Source 1's payload valid for 5 cycles before its header → s_ready_in[1]=0 until grant; no m_valid_in while IDLE.
- Source 0 holds a second header valid while its first packet streams → second header not acknowledged until the next grant (m_valid_insert=0 after hdr_done).
- m_ready_in toggled 1,0,1,0 during a 4-beat packet → beats forwarded in order with no loss or duplication; grant held throughout.
- rst_n pulsed low mid-packet (beat 2 of 5) → busy=0, all s_ready/m_valid=0 next cycle; after release, source 0 granted first.

Source files
------------

// File: rtl/axi_stream_insert_arbiter.sv
// ---------------------------------------------------------------------------
// axi_stream_insert_arbiter
//
// Shares one header-insert datapath between NUM_SRC packet sources. A source
// requests by raising its header valid. One source is granted per packet; its
// header channel and AXI-Stream payload are muxed onto the m_* ports. The
// grant is held until both the header handshake and the last payload beat
// handshake of that packet have completed.
//
// Build option:
//   ARB_FIXED_PRIO_EN  defined   -> lowest requesting index always wins.
//                      undefined -> round-robin starting after the last grant.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   s_*_insert            per-source header channel (valid/data/keep/cnt/ready)
//   s_*_in                per-source payload channel (valid/data/keep/last/ready)
//   m_*_insert            header channel towards the insert block
//   m_*_in                payload channel towards the insert block
//   grant_id              index of the granted source (meaningful when busy=1)
//   busy                  a packet is currently granted
// ---------------------------------------------------------------------------
module axi_stream_insert_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int NUM_SRC      = 2,
    parameter int SRC_ID_WD    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_SRC-1:0]                  s_valid_insert,
    input  logic [NUM_SRC*DATA_WD-1:0]          s_data_insert,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]     s_keep_insert,
    input  logic [NUM_SRC*(BYTE_CNT_WD+1)-1:0]  s_byte_insert_cnt,
    output logic [NUM_SRC-1:0]                  s_ready_insert,
    input  logic [NUM_SRC-1:0]                  s_valid_in,
    input  logic [NUM_SRC*DATA_WD-1:0]          s_data_in,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]     s_keep_in,
    input  logic [NUM_SRC-1:0]                  s_last_in,
    output logic [NUM_SRC-1:0]                  s_ready_in,
    output logic                                m_valid_insert,
    output logic [DATA_WD-1:0]                  m_data_insert,
    output logic [DATA_BYTE_WD-1:0]             m_keep_insert,
    output logic [BYTE_CNT_WD:0]                m_byte_insert_cnt,
    input  logic                                m_ready_insert,
    output logic                                m_valid_in,
    output logic [DATA_WD-1:0]                  m_data_in,
    output logic [DATA_BYTE_WD-1:0]             m_keep_in,
    output logic                                m_last_in,
    input  logic                                m_ready_in,
    output logic [SRC_ID_WD-1:0]                grant_id,
    output logic                                busy
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t                 state_reg, state_next;
    logic [SRC_ID_WD-1:0]   grant_id_reg, grant_id_next;
    logic                   hdr_done_reg, hdr_done_next;
    logic                   last_done_reg, last_done_next;

    logic [SRC_ID_WD-1:0]   winner;
    logic                   winner_found;
    logic [SRC_ID_WD-1:0]   cand;

    logic                   in_grant;
    logic                   hdr_open;
    logic                   pay_open;
    logic                   hdr_hs;
    logic                   last_hs;

    // Per-source unpacked views of the flat input buses, indexed by grant id.
    logic [DATA_WD-1:0]      data_insert_arr [NUM_SRC];
    logic [DATA_BYTE_WD-1:0] keep_insert_arr [NUM_SRC];
    logic [BYTE_CNT_WD:0]    cnt_insert_arr  [NUM_SRC];
    logic [DATA_WD-1:0]      data_in_arr     [NUM_SRC];
    logic [DATA_BYTE_WD-1:0] keep_in_arr     [NUM_SRC];

    assign in_grant = (state_reg == GRANT);
    // Once a channel of this packet has completed it is closed, so a second
    // header (or the next packet's payload) from the same source waits.
    assign hdr_open = in_grant & ~hdr_done_reg;
    assign pay_open = in_grant & ~last_done_reg;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign data_insert_arr[gi] = s_data_insert[gi*DATA_WD +: DATA_WD];
            assign keep_insert_arr[gi] = s_keep_insert[gi*DATA_BYTE_WD +: DATA_BYTE_WD];
            assign cnt_insert_arr[gi]  = s_byte_insert_cnt[gi*(BYTE_CNT_WD+1) +: (BYTE_CNT_WD+1)];
            assign data_in_arr[gi]     = s_data_in[gi*DATA_WD +: DATA_WD];
            assign keep_in_arr[gi]     = s_keep_in[gi*DATA_BYTE_WD +: DATA_BYTE_WD];

            assign s_ready_insert[gi] = hdr_open & (grant_id_reg == SRC_ID_WD'(gi)) & m_ready_insert;
            assign s_ready_in[gi]     = pay_open & (grant_id_reg == SRC_ID_WD'(gi)) & m_ready_in;
        end
    endgenerate

    // Master-side mux; everything is zero while idle.
    assign m_valid_insert    = hdr_open & s_valid_insert[grant_id_reg];
    assign m_data_insert     = in_grant ? data_insert_arr[grant_id_reg] : '0;
    assign m_keep_insert     = in_grant ? keep_insert_arr[grant_id_reg] : '0;
    assign m_byte_insert_cnt = in_grant ? cnt_insert_arr[grant_id_reg]  : '0;
    assign m_valid_in        = pay_open & s_valid_in[grant_id_reg];
    assign m_data_in         = in_grant ? data_in_arr[grant_id_reg] : '0;
    assign m_keep_in         = in_grant ? keep_in_arr[grant_id_reg] : '0;
    assign m_last_in         = in_grant & s_last_in[grant_id_reg];

    assign hdr_hs  = m_valid_insert & m_ready_insert;
    assign last_hs = m_valid_in & m_ready_in & m_last_in;

    assign grant_id = grant_id_reg;
    assign busy     = in_grant;

`ifdef ARB_FIXED_PRIO_EN
    // Scan from the highest index down so the lowest requester is kept last.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        cand         = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand = SRC_ID_WD'(k);
            if (s_valid_insert[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end
`else
    logic [SRC_ID_WD-1:0] ptr_reg;

    // Candidates are visited farthest-first so the one right after the
    // pointer (offset 1) overrides all others when it requests.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        cand         = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = SRC_ID_WD'((int'(ptr_reg) + k) % NUM_SRC);
            if (s_valid_insert[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

    // Pointer remembers the source of the packet that just finished.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg <= SRC_ID_WD'(NUM_SRC - 1);
        end else if (state_reg == GRANT && state_next == IDLE) begin
            ptr_reg <= grant_id_reg;
        end
    end
`endif

    always_comb begin
        state_next     = state_reg;
        grant_id_next  = grant_id_reg;
        hdr_done_next  = hdr_done_reg;
        last_done_next = last_done_reg;
        case (state_reg)
            IDLE: begin
                if (winner_found) begin
                    state_next     = GRANT;
                    grant_id_next  = winner;
                    hdr_done_next  = 1'b0;
                    last_done_next = 1'b0;
                end
            end
            GRANT: begin
                // Either channel may finish first; the packet ends only when
                // both have, counting handshakes that happen this cycle.
                if ((hdr_done_reg | hdr_hs) && (last_done_reg | last_hs)) begin
                    state_next     = IDLE;
                    hdr_done_next  = 1'b0;
                    last_done_next = 1'b0;
                end else begin
                    hdr_done_next  = hdr_done_reg | hdr_hs;
                    last_done_next = last_done_reg | last_hs;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            grant_id_reg  <= '0;
            hdr_done_reg  <= 1'b0;
            last_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_id_reg  <= grant_id_next;
            hdr_done_reg  <= hdr_done_next;
            last_done_reg <= last_done_next;
        end
    end

endmodule

// File: tb/tb_axi_stream_insert_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for axi_stream_insert_arbiter (NUM_SRC=2, DATA_WD=32).
// Sources are fed from per-source packet stores; a packet-level reference
// model decides which source should own the insert block and what it must
// see each cycle. Works for both the round-robin build and the
// ARB_FIXED_PRIO_EN build.
// ---------------------------------------------------------------------------
module tb_axi_stream_insert_arbiter;
    localparam int N  = 2;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int CW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]    s_valid_insert = '0;
    logic [N*DW-1:0] s_data_insert = '0;
    logic [N*BW-1:0] s_keep_insert = '0;
    logic [N*CW-1:0] s_byte_insert_cnt = '0;
    logic [N-1:0]    s_ready_insert;
    logic [N-1:0]    s_valid_in = '0;
    logic [N*DW-1:0] s_data_in = '0;
    logic [N*BW-1:0] s_keep_in = '0;
    logic [N-1:0]    s_last_in = '0;
    logic [N-1:0]    s_ready_in;
    logic            m_valid_insert;
    logic [DW-1:0]   m_data_insert;
    logic [BW-1:0]   m_keep_insert;
    logic [CW-1:0]   m_byte_insert_cnt;
    logic            m_ready_insert = 1'b0;
    logic            m_valid_in;
    logic [DW-1:0]   m_data_in;
    logic [BW-1:0]   m_keep_in;
    logic            m_last_in;
    logic            m_ready_in = 1'b0;
    logic [0:0]      grant_id;
    logic            busy;

    axi_stream_insert_arbiter #(.DATA_WD(DW), .NUM_SRC(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid_insert(s_valid_insert), .s_data_insert(s_data_insert),
        .s_keep_insert(s_keep_insert), .s_byte_insert_cnt(s_byte_insert_cnt),
        .s_ready_insert(s_ready_insert),
        .s_valid_in(s_valid_in), .s_data_in(s_data_in), .s_keep_in(s_keep_in),
        .s_last_in(s_last_in), .s_ready_in(s_ready_in),
        .m_valid_insert(m_valid_insert), .m_data_insert(m_data_insert),
        .m_keep_insert(m_keep_insert), .m_byte_insert_cnt(m_byte_insert_cnt),
        .m_ready_insert(m_ready_insert),
        .m_valid_in(m_valid_in), .m_data_in(m_data_in), .m_keep_in(m_keep_in),
        .m_last_in(m_last_in), .m_ready_in(m_ready_in),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Source packet stores: header {cnt, keep, data}, beat {last, keep, data}.
    logic [38:0] hdr_mem  [N][64];
    logic [36:0] beat_mem [N][256];
    int hdr_wr[N], hdr_rd[N], beat_wr[N], beat_rd[N];
    bit hv[N], bv[N], hdr_en[N], pay_en[N];
    int hdr_pct, pay_pct, rdy_pct;
    bit toggle_rdy_in;

    // Packet-level reference: who owns the insert block, which channels of
    // the current packet are finished, and the last source that was granted.
    bit mdl_busy, mdl_hdr_sent, mdl_last_sent;
    int mdl_grant, mdl_last_win;

    // Observations of the DUT for scenario-level checks.
    int glog[$];
    bit dut_busy_q;
    int busy_cycles, dut_hdr_hs;

    function automatic bit pending();
        for (int s = 0; s < N; s++)
            if (hdr_rd[s] != hdr_wr[s] || beat_rd[s] != beat_wr[s]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_src();
        for (int s = 0; s < N; s++) begin
            hdr_rd[s] = 0; hdr_wr[s] = 0; beat_rd[s] = 0; beat_wr[s] = 0;
            hv[s] = 1'b0; bv[s] = 1'b0;
        end
    endtask

    task automatic setup(input int hp, input int pp, input int rp, input bit tog);
        hdr_pct = hp; pay_pct = pp; rdy_pct = rp; toggle_rdy_in = tog;
        for (int s = 0; s < N; s++) begin hdr_en[s] = 1'b1; pay_en[s] = 1'b1; end
        glog.delete();
        busy_cycles = 0;
        dut_hdr_hs  = 0;
    endtask

    task automatic push_pkt(input int s, input int nb, input logic [31:0] hd,
                            input logic [3:0] hk, input logic [2:0] hc, input logic [3:0] lk);
        hdr_mem[s][hdr_wr[s]] = {hc, hk, hd};
        hdr_wr[s]++;
        for (int b = 0; b < nb; b++) begin
            beat_mem[s][beat_wr[s]] = {(b == nb - 1), (b == nb - 1) ? lk : 4'hF, $urandom()};
            beat_wr[s]++;
        end
    endtask

    // Source and sink behaviour: a valid once raised is held until the
    // reference model says it was accepted.
    task automatic drive();
        for (int s = 0; s < N; s++) begin
            if (!hv[s] && hdr_rd[s] != hdr_wr[s] && hdr_en[s] && $urandom_range(99) < hdr_pct) hv[s] = 1'b1;
            if (!bv[s] && beat_rd[s] != beat_wr[s] && pay_en[s] && $urandom_range(99) < pay_pct) bv[s] = 1'b1;
            s_valid_insert[s] = hv[s];
            {s_byte_insert_cnt[s*CW +: CW], s_keep_insert[s*BW +: BW], s_data_insert[s*DW +: DW]} =
                hv[s] ? hdr_mem[s][hdr_rd[s]] : 39'd0;
            s_valid_in[s] = bv[s];
            {s_last_in[s], s_keep_in[s*BW +: BW], s_data_in[s*DW +: DW]} =
                bv[s] ? beat_mem[s][beat_rd[s]] : 37'd0;
        end
        m_ready_insert = ($urandom_range(99) < rdy_pct);
        if (toggle_rdy_in) m_ready_in = mdl_busy ? ~m_ready_in : 1'b0;
        else               m_ready_in = ($urandom_range(99) < rdy_pct);
    endtask

    // One clock: drive, compare at the falling edge, advance the model at the
    // rising edge, return 1 time unit after it.
    task automatic tick();
        logic exp_mvi, exp_mvin, hs_h, hs_b;
        logic [N-1:0] exp_sri, exp_srin;
        int g, win, c;
        drive();
        @(negedge clk);
        cyc++;
        g        = mdl_grant;
        exp_mvi  = mdl_busy && !mdl_hdr_sent  && hv[g];
        exp_mvin = mdl_busy && !mdl_last_sent && bv[g];
        exp_sri  = '0;
        exp_srin = '0;
        if (mdl_busy && !mdl_hdr_sent)  exp_sri[g]  = m_ready_insert;
        if (mdl_busy && !mdl_last_sent) exp_srin[g] = m_ready_in;

        checks++;
        if (busy !== mdl_busy) begin
            failures++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, mdl_busy);
        end
        checks++;
        if (m_valid_insert !== exp_mvi) begin
            failures++; $display("FAIL m_valid_insert cyc=%0d got=%b exp=%b", cyc, m_valid_insert, exp_mvi);
        end
        checks++;
        if (m_valid_in !== exp_mvin) begin
            failures++; $display("FAIL m_valid_in cyc=%0d got=%b exp=%b", cyc, m_valid_in, exp_mvin);
        end
        checks++;
        if (s_ready_insert !== exp_sri) begin
            failures++; $display("FAIL s_ready_insert cyc=%0d got=%b exp=%b", cyc, s_ready_insert, exp_sri);
        end
        checks++;
        if (s_ready_in !== exp_srin) begin
            failures++; $display("FAIL s_ready_in cyc=%0d got=%b exp=%b", cyc, s_ready_in, exp_srin);
        end
        if (mdl_busy) begin
            checks++;
            if (grant_id !== 1'(g)) begin
                failures++; $display("FAIL grant_id cyc=%0d got=%0d exp=%0d", cyc, grant_id, g);
            end
        end
        if (exp_mvi) begin
            checks++;
            if ({m_byte_insert_cnt, m_keep_insert, m_data_insert} !== hdr_mem[g][hdr_rd[g]]) begin
                failures++;
                $display("FAIL header cyc=%0d got=%h exp=%h", cyc,
                         {m_byte_insert_cnt, m_keep_insert, m_data_insert}, hdr_mem[g][hdr_rd[g]]);
            end
        end
        if (exp_mvin) begin
            checks++;
            if ({m_last_in, m_keep_in, m_data_in} !== beat_mem[g][beat_rd[g]]) begin
                failures++;
                $display("FAIL beat cyc=%0d got=%h exp=%h", cyc,
                         {m_last_in, m_keep_in, m_data_in}, beat_mem[g][beat_rd[g]]);
            end
        end

        if (busy === 1'b1 && !dut_busy_q) glog.push_back(int'(grant_id));
        dut_busy_q = (busy === 1'b1);
        if (busy === 1'b1) busy_cycles++;
        if ((s_valid_insert & s_ready_insert) != '0) dut_hdr_hs++;
        hs_h = exp_mvi && m_ready_insert;
        hs_b = exp_mvin && m_ready_in;

        @(posedge clk);
        if (!rst_n) begin
            mdl_busy = 1'b0; mdl_hdr_sent = 1'b0; mdl_last_sent = 1'b0;
            mdl_grant = 0; mdl_last_win = N - 1;
        end else if (!mdl_busy) begin
            win = -1;
`ifdef ARB_FIXED_PRIO_EN
            for (int k = 0; k < N; k++) if (hv[k]) begin win = k; break; end
`else
            for (int k = 1; k <= N; k++) begin
                c = (mdl_last_win + k) % N;
                if (hv[c]) begin win = c; break; end
            end
`endif
            if (win >= 0) begin
                mdl_busy = 1'b1; mdl_grant = win; mdl_last_win = win;
                mdl_hdr_sent = 1'b0; mdl_last_sent = 1'b0;
            end
        end else begin
            if (hs_h) begin hdr_rd[g]++; hv[g] = 1'b0; mdl_hdr_sent = 1'b1; end
            if (hs_b) begin
                if (beat_mem[g][beat_rd[g]][36]) mdl_last_sent = 1'b1;
                beat_rd[g]++; bv[g] = 1'b0;
            end
            if (mdl_hdr_sent && mdl_last_sent) mdl_busy = 1'b0;
        end
        #1;
    endtask

    task automatic run_until_done(input string name, input int budget);
        for (int c = 0; c < budget && (pending() || mdl_busy); c++) tick();
        checks++;
        if (pending() || mdl_busy) begin
            failures++; $display("FAIL %s timeout got=pending exp=drained after %0d cycles", name, budget);
        end
    endtask

    task automatic do_reset();
        clear_src();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, grant_id, m_valid_insert, m_valid_in, s_ready_insert, s_ready_in} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0",
                     {busy, grant_id, m_valid_insert, m_valid_in, s_ready_insert, s_ready_in});
        end
        checks++;
        if ({m_data_insert, m_keep_insert, m_byte_insert_cnt, m_data_in, m_keep_in, m_last_in} !== '0) begin
            failures++; $display("FAIL reset_data got=nonzero exp=0");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        $display("test_reset done cyc=%0d", cyc);
    endtask

    task automatic test_single();
        setup(100, 100, 70, 1'b0);
        clear_src();
        push_pkt(0, 3, 32'hA5A5A5A5, 4'b0011, 3'd2, 4'b1100);
        tick();
        checks++;
        if (busy !== 1'b1 || grant_id !== 1'b0) begin
            failures++; $display("FAIL single_latency got=busy%b/id%0d exp=busy1/id0", busy, grant_id);
        end
        run_until_done("single", 100);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL single_end_busy got=%b exp=0", busy);
        end
        checks++;
        if (glog.size() != 1 || glog[0] != 0) begin
            failures++; $display("FAIL single_grants got=%p exp='{0}", glog);
        end
        $display("test_single done cyc=%0d", cyc);
    endtask

    task automatic test_round_robin();
        int exp_order[4];
        do_reset();
        setup(100, 100, 60, 1'b0);
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < N; s++)
                push_pkt(s, 2, $urandom(), 4'($urandom()), 3'($urandom_range(4)), 4'($urandom()));
`ifdef ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 1, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        run_until_done("round_robin", 400);
        checks++;
        if (glog.size() != 4) begin
            failures++; $display("FAIL rr_count got=%0d exp=4", glog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (glog[i] != exp_order[i]) begin
                    failures++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, glog[i], exp_order[i]);
                end
            end
        end
        $display("test_round_robin done grants=%p", glog);
    endtask

    task automatic test_early_payload();
        setup(100, 100, 100, 1'b0);
        clear_src();
        hdr_en[1] = 1'b0;
        push_pkt(1, 3, $urandom(), 4'hF, 3'd4, 4'b0111);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (s_ready_in[1] !== 1'b0 || m_valid_in !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL early_payload[%0d] got=rdy%b/mv%b/busy%b exp=0/0/0", i, s_ready_in[1], m_valid_in, busy);
            end
        end
        hdr_en[1] = 1'b1;
        run_until_done("early_payload", 100);
        checks++;
        if (glog.size() != 1 || glog[0] != 1) begin
            failures++; $display("FAIL early_grants got=%p exp='{1}", glog);
        end
        $display("test_early_payload done cyc=%0d", cyc);
    endtask

    task automatic test_second_header();
        setup(100, 30, 100, 1'b0);
        clear_src();
        push_pkt(0, 4, $urandom(), 4'hF, 3'd1, 4'b0001);
        push_pkt(0, 2, $urandom(), 4'h3, 3'd3, 4'b0011);
        run_until_done("second_header", 300);
        checks++;
        if (dut_hdr_hs != 2) begin
            failures++; $display("FAIL second_hdr_hs got=%0d exp=2", dut_hdr_hs);
        end
        checks++;
        if (glog.size() != 2 || glog[0] != 0 || glog[1] != 0) begin
            failures++; $display("FAIL second_grants got=%p exp='{0,0}", glog);
        end
        $display("test_second_header done cyc=%0d", cyc);
    endtask

    task automatic test_ready_toggle();
        setup(100, 100, 100, 1'b1);
        clear_src();
        m_ready_in = 1'b0;
        push_pkt(0, 4, $urandom(), 4'hF, 3'd0, 4'b1111);
        run_until_done("ready_toggle", 100);
        checks++;
        if (busy_cycles != 7) begin
            failures++; $display("FAIL toggle_busy_cycles got=%0d exp=7", busy_cycles);
        end
        checks++;
        if (glog.size() != 1 || glog[0] != 0) begin
            failures++; $display("FAIL toggle_grants got=%p exp='{0}", glog);
        end
        toggle_rdy_in = 1'b0;
        $display("test_ready_toggle done cyc=%0d", cyc);
    endtask

    task automatic test_reset_mid();
        setup(100, 100, 100, 1'b0);
        clear_src();
        push_pkt(0, 5, $urandom(), 4'hF, 3'd2, 4'b0011);
        for (int c = 0; c < 50 && beat_rd[0] < 2; c++) tick();
        checks++;
        if (beat_rd[0] != 2 || busy !== 1'b1) begin
            failures++; $display("FAIL mid_reach got=beats%0d/busy%b exp=beats2/busy1", beat_rd[0], busy);
        end
        clear_src();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy, m_valid_insert, m_valid_in, s_ready_insert, s_ready_in} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%b exp=0", {busy, m_valid_insert, m_valid_in, s_ready_insert, s_ready_in});
        end
        glog.delete();
        push_pkt(0, 2, $urandom(), 4'hF, 3'd1, 4'b1000);
        push_pkt(1, 2, $urandom(), 4'hF, 3'd1, 4'b1000);
        run_until_done("reset_mid", 200);
        checks++;
        if (glog.size() != 2 || glog[0] != 0) begin
            failures++; $display("FAIL mid_first_grant got=%p exp=first 0 of 2", glog);
        end
        $display("test_reset_mid done grants=%p", glog);
    endtask

    task automatic test_random();
        setup(60, 70, 60, 1'b0);
        clear_src();
        for (int p = 0; p < 10; p++)
            for (int s = 0; s < N; s++)
                push_pkt(s, $urandom_range(1, 5), $urandom(), 4'($urandom()),
                         3'($urandom_range(4)), 4'($urandom()));
        run_until_done("random", 3000);
        checks++;
        if (glog.size() != 20) begin
            failures++; $display("FAIL random_grants got=%0d exp=20", glog.size());
        end
        $display("test_random done cyc=%0d grants=%0d", cyc, glog.size());
    endtask

    initial begin
        clear_src();
        setup(100, 100, 100, 1'b0);
        mdl_busy = 1'b0; mdl_hdr_sent = 1'b0; mdl_last_sent = 1'b0;
        mdl_grant = 0; mdl_last_win = N - 1; dut_busy_q = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_early_payload();
        test_second_header();
        test_ready_toggle();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
